// File: rtl/i2s_pkg.sv
// Shared types and helpers for I2S sample packing/unpacking.
package i2s_pkg;

    typedef enum logic [1:0] {
        PACK_NONE = 2'd0,
        PACK_2X16 = 2'd1,
        PACK_4X8  = 2'd2
    } pack_mode_e;

    function automatic logic [2:0] pack_lanes(pack_mode_e mode);
        case (mode)
            PACK_2X16: return 3'd2;
            PACK_4X8:  return 3'd4;
            default:   return 3'd1;
        endcase
    endfunction

    // Encoding 2'b11 is reserved and behaves as unpacked.
    function automatic pack_mode_e decode_pack(logic [1:0] cfg);
        case (cfg)
            2'b01:   return PACK_2X16;
            2'b10:   return PACK_4X8;
            default: return PACK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/i2s_rx_norm.sv
// Combinational sample normaliser: MSB-aligned copy and masked/sign-extended
// right-aligned copy of a sample of (i_wlen+1) bits.
module i2s_rx_norm (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_wlen,
    input  logic        i_sext,
    output logic [31:0] o_norm,
    output logic [31:0] o_word
);

    logic [4:0]  w_lshift;
    logic [31:0] w_mask;
    logic        w_sign;

    always_comb begin
        w_lshift = 5'd31 - i_wlen;
        o_norm   = i_data << w_lshift;
        w_mask   = 32'hFFFF_FFFF >> w_lshift;
        w_sign   = i_data[i_wlen];
        o_word   = (i_data & w_mask) | ((i_sext && w_sign) ? ~w_mask : '0);
    end

endmodule

// File: rtl/i2s_rx_packer.sv
// Packs right-aligned I2S RX samples into 32-bit words (1x32, 2x16, 4x8)
// with a single-entry output register ahead of the CDC FIFO.
module i2s_rx_packer
    import i2s_pkg::*;
(
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic [31:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    input  logic        cfg_en_i,
    input  logic [1:0]  cfg_pack_i,
    input  logic [4:0]  cfg_wlen_i,
    input  logic        cfg_sext_i
);

    pack_mode_e  r_mode;
    logic [1:0]  r_lane;
    logic [31:0] r_acc;
    logic [31:0] r_out_data;
    logic        r_out_valid;

    logic [31:0] w_norm;
    logic [31:0] w_word;
    pack_mode_e  w_cur_mode;
    logic [2:0]  w_lanes;
    logic        w_last;
    logic [31:0] w_lane_word;
    logic        w_accept;

    i2s_rx_norm u_norm (
        .i_data (in_data_i),
        .i_wlen (cfg_wlen_i),
        .i_sext (cfg_sext_i),
        .o_norm (w_norm),
        .o_word (w_word)
    );

    // The first lane of a word uses the live config, which is latched on accept.
    always_comb begin
        w_cur_mode  = (r_lane == 2'd0) ? decode_pack(cfg_pack_i) : r_mode;
        w_lanes     = pack_lanes(w_cur_mode);
        w_last      = ({1'b0, r_lane} == (w_lanes - 3'd1));
        w_lane_word = '0;
        case (w_cur_mode)
            PACK_2X16: w_lane_word = (w_norm >> 16) << {r_lane[0], 4'b0000};
            PACK_4X8:  w_lane_word = (w_norm >> 24) << {r_lane, 3'b000};
            default:   w_lane_word = w_word;
        endcase
        in_ready_o = ~cfg_en_i | ~(w_last & r_out_valid & ~out_ready_i);
        w_accept   = in_valid_i & in_ready_o & cfg_en_i;
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mode      <= PACK_NONE;
            r_lane      <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (!cfg_en_i) begin
                r_lane <= '0;
                r_acc  <= '0;
            end else if (w_accept) begin
                if (r_lane == 2'd0) begin
                    r_mode <= w_cur_mode;
                end
                if (w_last) begin
                    r_out_data <= r_acc | w_lane_word;
                    r_acc      <= '0;
                    r_lane     <= '0;
                end else begin
                    r_acc  <= r_acc | w_lane_word;
                    r_lane <= r_lane + 2'd1;
                end
            end

            // A completion in the same cycle as an output accept keeps valid high.
            if (w_accept && w_last) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data_o  = r_out_data;
    assign out_valid_o = r_out_valid;

endmodule

// File: doc/i2s_rx_packer.md
# i2s_rx_packer

Sample packer directly downstream of the I2S RX channel, in the `sck_i` domain. It accepts one right-aligned sample per handshake from the channel's `fifo_data_o`/`fifo_data_valid_o`/`fifo_data_ready_i` port. It emits 32-bit words toward the clock-domain-crossing FIFO, either one sample per word or packed 2×16 / 4×8. Its single-entry output buffer lets packing continue while one completed word waits on the FIFO.

## Interface
- No parameters; data width is fixed at 32.
- `sck_i`  in  1  I2S bit clock; the only clock. Everything samples on the rising edge.
- `rstn_i`  in  1  Reset, asynchronous active-low.
- `in_data_i`  in  32  Sample, right-aligned, significant bits `[cfg_wlen_i:0]`.
- `in_valid_i`  in  1  Sample valid.
- `in_ready_o`  out  1  Sample accepted when high together with `in_valid_i`.
- `out_data_o`  out  32  Packed word.
- `out_valid_o`  out  1  Word valid.
- `out_ready_i`  in  1  Downstream accepts the word.
- `cfg_en_i`  in  1  Enable. Low clears the accumulator and discards input.
- `cfg_pack_i`  in  2  Pack mode: 00 none, 01 2×16, 10 4×8, 11 treated as 00.
- `cfg_wlen_i`  in  5  Sample length minus one (same encoding as the RX channel).
- `cfg_sext_i`  in  1  Unpacked mode only: sign-extend from bit `cfg_wlen_i`; otherwise zero-fill.

## Operation
- **Normalisation (combinational):**
  - `norm = in_data_i << (31 - cfg_wlen_i)`, which MSB-aligns the sample.
  - 16-bit lane value is `norm[31:16]`; 8-bit lane value is `norm[31:24]`. Samples shorter than the lane are zero-padded in the LSBs.
- **Unpacked word:** bits above `cfg_wlen_i` are cleared, then filled with bit `cfg_wlen_i` if `cfg_sext_i`, else with zeros.
- **Lanes:** N = 1, 2 or 4. The first sample of a word goes to the lowest lane (bits `[7:0]` or `[15:0]`). Bits not written stay 0.
- **Lane counter `lane_q`:** counts 0..N-1 and wraps to 0 on the last lane. Channel interleaving from the RX block (ch0, ch1, ch0, …) is preserved in order.
- **Mode latch:** `cfg_pack_i` is captured into `mode_q` only on an accepted sample with `lane_q==0`. Configuration changes mid-word take effect at the next word.
- **Word completion:** on the last lane, `{lane value, acc_q}` is transferred to the output register, `out_valid_o` is set, and `acc_q` is cleared.
- **Backpressure:** `in_ready_o = ~cfg_en_i | ~(last_lane & out_valid_o & ~out_ready_i)`. This is a combinational path from `out_ready_i`. Non-last lanes are always accepted.
- **Disable:**
  - While `cfg_en_i` is low: `in_ready_o` is 1, input is dropped, and `acc_q` and `lane_q` are held at 0.
  - A partial word is discarded on the first cycle `cfg_en_i` is low.
  - A pending output word is kept until it is accepted.

## Timing
- **Reset values:**
  - `out_valid_o` = 0
  - `out_data_o` = 0
  - `in_ready_o` = 1
  - `lane_q` = 0, `acc_q` = 0, `mode_q` = none
- **Latency:** `out_valid_o` is high in the cycle after the last-lane sample is accepted. There is no bubble on back-to-back words when `out_ready_i` is high.
- **Output handshake:**
  - `out_data_o` and `out_valid_o` stay stable until `out_ready_i`.
  - On the accept cycle with no new completion, `out_valid_o` drops on the next edge.
- **Simultaneous events:**
  - Output accept and last-lane completion in the same cycle: the new word loads, and `out_valid_o` stays 1.
  - Disable coinciding with a last lane: the sample is discarded and no word is produced.
- **Reset mid-word:** all state returns to reset values asynchronously. There is no partial flush.

## Structure
- Package `i2s_pkg` holds:
  - `typedef enum logic [1:0] pack_mode_e {PACK_NONE, PACK_2X16, PACK_4X8}`.
  - Lane-count function `pack_lanes(pack_mode_e)`.
- The normaliser/sign-extender is a separate combinational sub-module, `i2s_rx_norm`. It is reused by TX-side unpacking.
- Top level holds the lane counter, accumulator, mode latch, output register and ready logic; about 150-200 lines.

## Test plan
- **Unpacked, zero-fill:** `cfg_pack_i=00`, wlen=15, sext=0, input 0x0000_8001 → output 0x0000_8001, one cycle later.
- **Unpacked, sign-extend:** same setup with sext=1 → output 0xFFFF_8001.
- **2×16, 24-bit samples:**
  - wlen=23, inputs 0x00AB_CDEF then 0x0012_3456 → single word 0x1234_ABCD.
  - `out_valid_o` rises the cycle after the second accept.
- **4×8, 8-bit samples:** wlen=7, inputs 0x11, 0x22, 0x33, 0x44 → 0x4433_2211. Then 0x55, 0x66, 0x77, 0x88 back-to-back with `out_ready_i`=1 → 0x8877_6655 with no gap.
- **Backpressure:**
  - 2×16 mode, `out_ready_i`=0 with a word pending.
  - First lane of the next word is accepted; on the last lane `in_ready_o`=0.
  - Raise `out_ready_i` → both words delivered in order, and no sample is lost.
- **Disable and reconfigure:**
  - 4×8 mode with 2 lanes filled, then drop `cfg_en_i` for one cycle → the partial word is discarded.
  - Re-enable with `cfg_pack_i=01` → the next word follows 2×16 packing.
  - Async reset mid-word → all outputs return to reset values immediately.
